// File: rtl/stopwatch_pkg.sv
// Shared state/event types, defaults and FSM helper functions for the
// stopwatch control block.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      LAP   = 2'd3
   } sw_state_t;

   typedef enum logic [2:0] {
      EV_NONE  = 3'd0,
      EV_CLEAR = 3'd1,
      EV_STOP  = 3'd2,
      EV_START = 3'd3,
      EV_LAP   = 3'd4
   } sw_event_t;

   localparam int unsigned DB_CYCLES_DEFAULT   = 1000000;
   localparam int unsigned SYNC_STAGES_DEFAULT = 2;

   // Only the highest-priority press in a cycle survives: clear > stop > start > lap.
   function automatic sw_event_t pick_event(input logic clear,
                                            input logic stop,
                                            input logic start,
                                            input logic lap);
      if (clear)      return EV_CLEAR;
      else if (stop)  return EV_STOP;
      else if (start) return EV_START;
      else if (lap)   return EV_LAP;
      else            return EV_NONE;
   endfunction

   function automatic logic is_active(input sw_state_t s);
      return (s == RUN) || (s == LAP);
   endfunction

   function automatic sw_state_t next_state(input sw_state_t s, input sw_event_t ev);
      sw_state_t n;
      n = s;
      unique case (ev)
         EV_CLEAR: n = IDLE;
         EV_STOP:  if (s == RUN || s == LAP) n = PAUSE;
         EV_START: if (s == IDLE || s == PAUSE) n = RUN;
         EV_LAP: begin
            if (s == RUN)      n = LAP;
            else if (s == LAP) n = RUN;
         end
         default: n = s;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw push-button conditioning: synchronizer, stable-level debouncer and
// single-cycle press event on an accepted 0->1 transition.
module button_debounce
   import stopwatch_pkg::*;
#(
   parameter int unsigned DB_CYCLES   = DB_CYCLES_DEFAULT,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic clock_in,
   input  logic reset_n,
   input  logic btn,
   output logic press
);

   localparam int unsigned CW = $clog2(DB_CYCLES + 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   synced;
   logic                   accepted;
   logic [CW-1:0]          cnt;

   assign synced = sync[SYNC_STAGES-1];

   // Counter only runs while the synced level disagrees with the accepted one.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         sync     <= '0;
         accepted <= 1'b0;
         cnt      <= '0;
         press    <= 1'b0;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], btn};
         press <= 1'b0;
         if (synced == accepted) begin
            cnt <= '0;
         end else if (cnt == CW'(DB_CYCLES - 1)) begin
            cnt      <= '0;
            accepted <= synced;
            press    <= synced;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: debounced buttons and divided ticks in, count-enable,
// clear pulse and lap display-hold out, all in the clock_in domain.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned DB_CYCLES   = DB_CYCLES_DEFAULT,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic       clock_in,
   input  logic       reset_n,
   input  logic       start_btn,
   input  logic       stop_btn,
   input  logic       clear_btn,
   input  logic       lap_btn,
   input  logic       speed_sw,
   input  logic       tick_1hz,
   input  logic       tick_2hz,
   output logic       count_en,
   output logic       clear_pulse,
   output logic       running,
   output logic       display_hold,
   output logic       speed_mode,
   output logic [1:0] state_o
);

   logic press_start;
   logic press_stop;
   logic press_clear;
   logic press_lap;

   button_debounce #(.DB_CYCLES(DB_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_db_start (
      .clock_in (clock_in),
      .reset_n  (reset_n),
      .btn      (start_btn),
      .press    (press_start)
   );

   button_debounce #(.DB_CYCLES(DB_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_db_stop (
      .clock_in (clock_in),
      .reset_n  (reset_n),
      .btn      (stop_btn),
      .press    (press_stop)
   );

   button_debounce #(.DB_CYCLES(DB_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_db_clear (
      .clock_in (clock_in),
      .reset_n  (reset_n),
      .btn      (clear_btn),
      .press    (press_clear)
   );

   button_debounce #(.DB_CYCLES(DB_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_db_lap (
      .clock_in (clock_in),
      .reset_n  (reset_n),
      .btn      (lap_btn),
      .press    (press_lap)
   );

   logic [SYNC_STAGES-1:0] speed_sync;

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         speed_sync <= '0;
      end else begin
         speed_sync <= {speed_sync[SYNC_STAGES-2:0], speed_sw};
      end
   end

   assign speed_mode = speed_sync[SYNC_STAGES-1];

   // Both edge detectors always run so changing speed_mode never fakes an edge.
   logic tick_1hz_q;
   logic tick_2hz_q;
   logic edge_1hz;
   logic edge_2hz;
   logic edge_sel;

   assign edge_1hz = tick_1hz & ~tick_1hz_q;
   assign edge_2hz = tick_2hz & ~tick_2hz_q;
   assign edge_sel = speed_mode ? edge_2hz : edge_1hz;

   sw_state_t state;
   sw_state_t state_nxt;
   sw_event_t ev;

   always_comb begin
      ev        = pick_event(press_clear, press_stop, press_start, press_lap);
      state_nxt = next_state(state, ev);
   end

   // Outputs decode state_nxt so they change on the same edge as the state;
   // count_en looks at the current state, so a start coincident with an edge
   // does not count while a stop/clear coincident with an edge still does.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         state_o      <= '0;
         running      <= 1'b0;
         display_hold <= 1'b0;
         clear_pulse  <= 1'b0;
         count_en     <= 1'b0;
         tick_1hz_q   <= 1'b0;
         tick_2hz_q   <= 1'b0;
      end else begin
         tick_1hz_q   <= tick_1hz;
         tick_2hz_q   <= tick_2hz;
         state        <= state_nxt;
         state_o      <= state_nxt;
         running      <= is_active(state_nxt);
         display_hold <= (state_nxt == LAP);
         clear_pulse  <= (ev == EV_CLEAR);
         count_en     <= edge_sel & is_active(state);
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with DB_CYCLES=4, SYNC_STAGES=2 and
// 16/8-cycle tick periods.
module tb_stopwatch_ctrl;

   localparam int unsigned DB = 4;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;
   localparam logic [1:0] S_LAP   = 2'd3;

   // button mask bits: {lap, clear, stop, start}
   localparam logic [3:0] M_START = 4'b0001;
   localparam logic [3:0] M_STOP  = 4'b0010;
   localparam logic [3:0] M_CLEAR = 4'b0100;
   localparam logic [3:0] M_LAP   = 4'b1000;

   localparam int SIG_STATE = 0;
   localparam int SIG_RUN   = 1;
   localparam int SIG_HOLD  = 2;
   localparam int SIG_CLR   = 3;
   localparam int SIG_SPD   = 4;
   localparam int SIG_CE    = 5;

   logic       clock_in;
   logic       reset_n;
   logic       start_btn;
   logic       stop_btn;
   logic       clear_btn;
   logic       lap_btn;
   logic       speed_sw;
   logic       tick_1hz;
   logic       tick_2hz;
   logic       count_en;
   logic       clear_pulse;
   logic       running;
   logic       display_hold;
   logic       speed_mode;
   logic [1:0] state_o;

   typedef struct {
      int         cyc;
      int         sig;
      logic [1:0] val;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   ce_q[$];

   int         cyc        = 0;
   int         errors     = 0;
   int         checks     = 0;
   logic       mon_en     = 1'b0;
   logic [1:0] mstate     = S_IDLE;
   logic       mspeed     = 1'b0;
   int         pend_cyc   = -1;
   logic [1:0] pend_state = S_IDLE;
   int         spd_cyc    = -1;
   logic       spd_val    = 1'b0;

   stopwatch_ctrl #(.DB_CYCLES(DB), .SYNC_STAGES(2)) dut (
      .clock_in     (clock_in),
      .reset_n      (reset_n),
      .start_btn    (start_btn),
      .stop_btn     (stop_btn),
      .clear_btn    (clear_btn),
      .lap_btn      (lap_btn),
      .speed_sw     (speed_sw),
      .tick_1hz     (tick_1hz),
      .tick_2hz     (tick_2hz),
      .count_en     (count_en),
      .clear_pulse  (clear_pulse),
      .running      (running),
      .display_hold (display_hold),
      .speed_mode   (speed_mode),
      .state_o      (state_o)
   );

   initial begin
      clock_in = 1'b0;
      forever #5 clock_in = ~clock_in;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   function automatic void expect_at(input int c, input int sig, input logic [1:0] v, input string tag);
      exp_t x;
      x.cyc = c;
      x.sig = sig;
      x.val = v;
      x.tag = tag;
      sb.push_back(x);
   endfunction

   function automatic int sample(input int sig);
      case (sig)
         SIG_STATE: return int'(state_o);
         SIG_RUN:   return int'(running);
         SIG_HOLD:  return int'(display_hold);
         SIG_CLR:   return int'(clear_pulse);
         SIG_SPD:   return int'(speed_mode);
         default:   return int'(count_en);
      endcase
   endfunction

   // Reference transition table with clear > stop > start > lap priority.
   function automatic logic [1:0] next_of(input logic [1:0] s, input logic [3:0] m);
      if (m[2]) return S_IDLE;
      if (m[1]) return (s == S_RUN || s == S_LAP) ? S_PAUSE : s;
      if (m[0]) return (s == S_IDLE || s == S_PAUSE) ? S_RUN : s;
      if (m[3]) return (s == S_RUN) ? S_LAP : ((s == S_LAP) ? S_RUN : s);
      return s;
   endfunction

   // Cycle counter and tick generators: cycle n holds the values driven after posedge n.
   initial begin
      tick_1hz = 1'b0;
      tick_2hz = 1'b0;
      forever begin
         @(posedge clock_in);
         cyc++;
         #1;
         tick_1hz = (cyc % 16) >= 8;
         tick_2hz = (cyc % 8) >= 4;
      end
   end

   // Monitor: applies scheduled model changes, compares due scoreboard
   // entries and predicts count_en one cycle after each selected edge.
   initial begin
      forever begin
         @(negedge clock_in);
         if (mon_en) begin
            if (pend_cyc == cyc) mstate = pend_state;
            if (spd_cyc == cyc) mspeed = spd_val;

            if (ce_q.size() > 0 && ce_q[0] == cyc) begin
               void'(ce_q.pop_front());
               check("count_en", int'(count_en), 1);
            end else if (count_en) begin
               check("count_en_spurious", int'(count_en), 0);
            end

            for (int i = 0; i < sb.size(); ) begin
               if (sb[i].cyc == cyc) begin
                  check(sb[i].tag, sample(sb[i].sig), int'(sb[i].val));
                  sb.delete(i);
               end else begin
                  i++;
               end
            end

            if ((mspeed ? ((cyc % 8) == 4) : ((cyc % 16) == 8)) &&
                (mstate == S_RUN || mstate == S_LAP))
               ce_q.push_back(cyc + 1);
         end
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clock_in);
      #1;
   endtask

   // Press buttons in mask m for hold cycles; an accepted press changes state 7 cycles later.
   task automatic press(input logic [3:0] m, input int hold, input string tag);
      int         k;
      logic [1:0] ns;
      @(posedge clock_in);
      #1;
      k = cyc;
      {lap_btn, clear_btn, stop_btn, start_btn} = m;
      if (hold >= int'(DB)) begin
         ns         = next_of(mstate, m);
         pend_cyc   = k + 7;
         pend_state = ns;
         expect_at(k + 7, SIG_STATE, ns, {tag, "_state"});
         expect_at(k + 7, SIG_RUN, {1'b0, (ns == S_RUN || ns == S_LAP)}, {tag, "_running"});
         expect_at(k + 7, SIG_HOLD, {1'b0, (ns == S_LAP)}, {tag, "_hold"});
         expect_at(k + 7, SIG_CLR, {1'b0, m[2]}, {tag, "_clear_pulse"});
         expect_at(k + 8, SIG_CLR, 2'd0, {tag, "_clear_pulse_end"});
      end else begin
         expect_at(k + 7, SIG_STATE, mstate, {tag, "_state"});
         expect_at(k + 7, SIG_CLR, 2'd0, {tag, "_clear_pulse"});
      end
      repeat (hold) @(posedge clock_in);
      #1;
      {lap_btn, clear_btn, stop_btn, start_btn} = 4'b0000;
      wait_cycles(12);
   endtask

   task automatic set_speed(input logic v);
      @(posedge clock_in);
      #1;
      speed_sw = v;
      spd_cyc  = cyc + 2;
      spd_val  = v;
      expect_at(cyc + 2, SIG_SPD, {1'b0, v}, "speed_mode");
   endtask

   initial begin
      reset_n  = 1'b0;
      {lap_btn, clear_btn, stop_btn, start_btn} = 4'b0000;
      speed_sw = 1'b0;

      for (int i = 0; i < 10; i++) begin
         @(posedge clock_in);
         #1;
         {lap_btn, clear_btn, stop_btn, start_btn} = 4'($urandom_range(0, 15));
         speed_sw = 1'($urandom_range(0, 1));
      end
      @(negedge clock_in);
      check("rst_state", int'(state_o), 0);
      check("rst_count_en", int'(count_en), 0);
      check("rst_clear_pulse", int'(clear_pulse), 0);
      check("rst_running", int'(running), 0);
      check("rst_hold", int'(display_hold), 0);
      check("rst_speed", int'(speed_mode), 0);

      {lap_btn, clear_btn, stop_btn, start_btn} = 4'b0000;
      speed_sw = 1'b0;
      @(posedge clock_in);
      #1;
      reset_n = 1'b1;
      mon_en  = 1'b1;
      expect_at(cyc + 3, SIG_STATE, S_IDLE, "post_rst_state");
      expect_at(cyc + 3, SIG_RUN, 2'd0, "post_rst_running");
      wait_cycles(6);

      press(M_START, 3, "glitch_start");
      press(M_START, 10, "start");
      wait_cycles(40);

      set_speed(1'b1);
      wait_cycles(30);
      set_speed(1'b0);
      wait_cycles(24);

      press(M_LAP, 10, "lap_in");
      wait_cycles(20);
      press(M_LAP, 10, "lap_out");
      press(M_LAP, 10, "lap_in2");
      press(M_STOP, 10, "stop_from_lap");
      press(M_START, 10, "resume");
      press(M_STOP, 10, "stop");
      wait_cycles(20);
      press(M_START | M_STOP | M_LAP, 10, "prio_stop");
      press(M_CLEAR | M_START, 10, "prio_clear");
      wait_cycles(10);

      // Start event lands in the same cycle as a tick_1hz rising edge.
      for (int i = 0; i < 16 && (cyc % 16) != 1; i++) wait_cycles(1);
      expect_at(cyc + 8, SIG_CE, 2'd0, "coinc_no_ce");
      expect_at(cyc + 24, SIG_CE, 2'd1, "coinc_next_ce");
      press(M_START, 10, "coinc_start");
      wait_cycles(10);

      press(M_CLEAR, 10, "clear_run");
      press(M_CLEAR, 10, "clear_idle");
      wait_cycles(5);

      check("sb_drain", sb.size(), 0);
      check("ce_drain", ce_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
